// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-generator pipeline: source-format
// encodings and default widths.
package imm_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int IMM_W        = 25;
  localparam int SRC_W        = 3;

  typedef enum logic [SRC_W-1:0] {
    SRC_I     = 3'b000,
    SRC_S     = 3'b001,
    SRC_U     = 3'b010,
    SRC_SHAMT = 3'b011,
    SRC_CSR   = 3'b100,
    SRC_B     = 3'b101,
    SRC_J     = 3'b110,
    SRC_RSVD  = 3'b111
  } src_e;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Request/result handshake bundle for imm_gen_pipe; slave is the pipeline,
// master is whoever issues requests and drains results.
interface imm_gen_pipe_if
  import imm_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [IMM_W-1:0] in_imm;
  logic [SRC_W-1:0] in_src;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_ext;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport master (
    output in_valid, in_imm, in_src, in_tag, out_ready,
    input  in_ready, out_valid, out_ext, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_imm, in_src, in_tag, out_ready,
    output in_ready, out_valid, out_ext, out_tag, out_illegal
  );

endinterface

// File: rtl/imm_ext.sv
// Combinational immediate decoder: instruction bits [31:7] arrive as imm[24:0],
// so instr[k] is imm[k-7] throughout.
module imm_ext
  import imm_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [IMM_W-1:0] imm,
  input  src_e             src,
  output logic [XLEN-1:0]  ext,
  output logic             illegal
);

  logic sign;
  logic shamt_hi;

  assign sign = imm[24];
  // instr[25] only belongs to the shift amount on 64-bit datapaths
  assign shamt_hi = (XLEN == 64) ? imm[18] : 1'b0;

  always_comb begin
    ext     = '0;
    illegal = 1'b0;
    case (src)
      SRC_I:     ext = {{(XLEN-11){sign}}, imm[23:13]};
      SRC_S:     ext = {{(XLEN-11){sign}}, imm[23:18], imm[4:0]};
      SRC_B:     ext = {{(XLEN-12){sign}}, imm[0], imm[23:18], imm[4:1], 1'b0};
      SRC_U:     ext = {{(XLEN-31){sign}}, imm[23:5], 12'b0};
      SRC_J:     ext = {{(XLEN-20){sign}}, imm[12:5], imm[13], imm[23:14], 1'b0};
      SRC_SHAMT: ext = {{(XLEN-6){1'b0}}, shamt_hi, imm[17:13]};
      SRC_CSR:   ext = {{(XLEN-5){1'b0}}, imm[12:8]};
      SRC_RSVD:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a one-cycle-latency result FIFO: decodes each
// accepted request and queues the extended immediate alongside its tag.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  imm_gen_pipe_if.slave          bus,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             illegal_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  ext_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic             ill_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       illegal_cnt_q, illegal_cnt_d;

  logic [XLEN-1:0]  dec_ext;
  logic             dec_illegal;
  logic             not_empty;
  logic             push;
  logic             pop;

  imm_ext #(.XLEN(XLEN)) u_imm_ext (
    .imm     (bus.in_imm),
    .src     (src_e'(bus.in_src)),
    .ext     (dec_ext),
    .illegal (dec_illegal)
  );

  assign not_empty    = (count_q != '0);
  assign bus.in_ready = (count_q != CNT_W'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = not_empty && bus.out_ready;

  // Head fields are forced to zero while empty so stale entries never leak out
  assign bus.out_valid   = not_empty;
  assign bus.out_ext     = not_empty ? ext_mem[rd_ptr_q] : '0;
  assign bus.out_tag     = not_empty ? tag_mem[rd_ptr_q] : '0;
  assign bus.out_illegal = not_empty ? ill_mem[rd_ptr_q] : 1'b0;

  assign count       = count_q;
  assign illegal_cnt = illegal_cnt_q;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    illegal_cnt_d = illegal_cnt_q;

    // The statistic counts every accepted reserved request, flushed or not
    if (push && dec_illegal && (illegal_cnt_q != 8'hFF))
      illegal_cnt_d = illegal_cnt_q + 8'd1;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      illegal_cnt_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  // Storage needs no reset: an entry is only visible after it has been written
  always_ff @(posedge clk) begin
    if (push) begin
      ext_mem[wr_ptr_q] <= dec_ext;
      tag_mem[wr_ptr_q] <= bus.in_tag;
      ill_mem[wr_ptr_q] <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit and a 64-bit instance see the same
// stimulus; expected values come from hand-computed vector tables.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [2:0] cnt32, cnt64;
  logic [7:0] ill32, ill64;
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) bus32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) bus64 ();

  imm_gen_pipe #(.XLEN(32), .DEPTH(4), .TAG_W(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32),
    .count(cnt32), .illegal_cnt(ill32)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(4), .TAG_W(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus64),
    .count(cnt64), .illegal_cnt(ill64)
  );

  localparam int NV = 13;
  logic [24:0] v_imm [NV] = '{
    25'b0000000010100000000001000, 25'b0000000010100000000001000,
    25'b0000000010100000000001000, 25'b0000000010100000000001000,
    25'b0000000010100000000001000, 25'h1000000, 25'h0080000, 25'h0040000,
    25'h0001F00, 25'h1000000, 25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFF
  };
  logic [2:0] v_src [NV] = '{
    3'b000, 3'b001, 3'b101, 3'b010, 3'b110, 3'b000, 3'b011, 3'b011,
    3'b100, 3'b010, 3'b110, 3'b101, 3'b111
  };
  logic [63:0] v_e32 [NV] = '{
    64'h0000000A, 64'h00000008, 64'h00000008, 64'h00A00000, 64'h0000000A,
    64'hFFFFF800, 64'h0, 64'h0, 64'h1F, 64'h80000000, 64'hFFFFFFFE,
    64'hFFFFFFFE, 64'h0
  };
  logic [63:0] v_e64 [NV] = '{
    64'h0000000A, 64'h00000008, 64'h00000008, 64'h00A00000, 64'h0000000A,
    64'hFFFFFFFFFFFFF800, 64'h0, 64'h20, 64'h1F, 64'hFFFFFFFF80000000,
    64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 64'h0
  };

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic [24:0] imm, input logic [2:0] src,
                       input logic [4:0] tag);
    bus32.in_valid = v;  bus32.in_imm = imm;  bus32.in_src = src;  bus32.in_tag = tag;
    bus64.in_valid = v;  bus64.in_imm = imm;  bus64.in_src = src;  bus64.in_tag = tag;
  endtask

  task automatic set_ready(input logic r);
    bus32.out_ready = r;
    bus64.out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drive(1'b0, '0, 3'b000, '0);
    set_ready(1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst.count", cnt32, 0);
    check("rst.in_ready", bus32.in_ready, 1);
    check("rst.out_valid", bus32.out_valid, 0);
    check("rst.out_ext", bus32.out_ext, 0);
    check("rst.illegal_cnt", ill32, 0);
    rst_n = 1'b1;

    // Back-to-back decode vectors with the consumer always ready
    set_ready(1'b1);
    for (int k = 0; k < NV; k++) begin
      drive(1'b1, v_imm[k], v_src[k], 5'(k));
      tick();
      $display("vec %0d src=%0d imm=0x%h ext32=0x%h ext64=0x%h tag=%0d",
               k, v_src[k], v_imm[k], bus32.out_ext, bus64.out_ext, bus32.out_tag);
      check($sformatf("vec%0d.valid", k), bus32.out_valid, 1);
      check($sformatf("vec%0d.ext32", k), bus32.out_ext, v_e32[k]);
      check($sformatf("vec%0d.ext64", k), bus64.out_ext, v_e64[k]);
      check($sformatf("vec%0d.tag", k), bus32.out_tag, 64'(k));
      check($sformatf("vec%0d.illegal", k), bus32.out_illegal, 64'(v_src[k] == 3'b111));
      check($sformatf("vec%0d.count", k), cnt32, 1);
      check($sformatf("vec%0d.count64", k), cnt64, 1);
    end
    drive(1'b0, '0, 3'b000, '0);
    tick();
    check("drain.valid", bus32.out_valid, 0);
    check("drain.count", cnt32, 0);
    check("drain.ext", bus32.out_ext, 0);
    check("drain.tag", bus32.out_tag, 0);
    check("drain.illegal_cnt", ill32, 1);

    // Fill to capacity, stall a fifth request, then drain in order
    set_ready(1'b0);
    for (int t = 1; t <= 4; t++) begin
      drive(1'b1, '0, 3'b000, 5'(t));
      tick();
    end
    check("full.count", cnt32, 4);
    check("full.in_ready", bus32.in_ready, 0);
    check("full.head", bus32.out_tag, 1);
    drive(1'b1, '0, 3'b000, 5'd5);
    tick();
    check("stall.count", cnt32, 4);
    check("stall.head", bus32.out_tag, 1);
    set_ready(1'b1);
    tick();
    $display("drain head=%0d count=%0d", bus32.out_tag, cnt32);
    check("pop1.head", bus32.out_tag, 2);
    check("pop1.count", cnt32, 3);
    check("pop1.in_ready", bus32.in_ready, 1);
    tick();
    drive(1'b0, '0, 3'b000, '0);
    $display("drain head=%0d count=%0d", bus32.out_tag, cnt32);
    check("pop2.head", bus32.out_tag, 3);
    check("pop2.count", cnt32, 3);
    tick();
    check("pop3.head", bus32.out_tag, 4);
    check("pop3.count", cnt32, 2);
    tick();
    check("pop4.head", bus32.out_tag, 5);
    check("pop4.count", cnt32, 1);
    tick();
    check("pop5.valid", bus32.out_valid, 0);
    check("pop5.count", cnt32, 0);

    // Flush wins over a same-cycle push (reserved) and pop
    set_ready(1'b0);
    drive(1'b1, '0, 3'b000, 5'd10);
    tick();
    drive(1'b1, '0, 3'b000, 5'd11);
    tick();
    check("preflush.count", cnt32, 2);
    flush = 1'b1;
    set_ready(1'b1);
    drive(1'b1, 25'h1FFFFFF, 3'b111, 5'd12);
    tick();
    flush = 1'b0;
    set_ready(1'b0);
    drive(1'b0, '0, 3'b000, '0);
    $display("flush count=%0d valid=%0d illegal_cnt=%0d", cnt32, bus32.out_valid, ill32);
    check("flush.count", cnt32, 0);
    check("flush.valid", bus32.out_valid, 0);
    check("flush.illegal_cnt", ill32, 2);
    check("flush.in_ready", bus32.in_ready, 1);
    tick();
    check("flush.lost", cnt32, 0);
    drive(1'b1, v_imm[0], 3'b000, 5'd13);
    tick();
    drive(1'b0, '0, 3'b000, '0);
    check("postflush.valid", bus32.out_valid, 1);
    check("postflush.tag", bus32.out_tag, 13);
    check("postflush.ext", bus32.out_ext, 64'hA);
    check("postflush.count", cnt32, 1);
    set_ready(1'b1);
    tick();
    check("postflush.drain", cnt32, 0);

    // Saturating reserved-source counter
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 25'h1FFFFFF, 3'b111, 5'(i));
      tick();
      check($sformatf("rsvd%0d.illegal", i), bus32.out_illegal, 1);
      check($sformatf("rsvd%0d.ext", i), bus32.out_ext, 0);
      check($sformatf("rsvd%0d.ext64", i), bus64.out_ext, 0);
      if (i == 99)
        check("rsvd.cnt_mid", ill32, 102);
    end
    $display("reserved burst done illegal_cnt=%0d/%0d", ill32, ill64);
    check("rsvd.cnt_sat", ill32, 255);
    check("rsvd.cnt_sat64", ill64, 255);
    drive(1'b0, '0, 3'b000, '0);
    tick();
    check("rsvd.drain", cnt32, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush.keeps_cnt", ill32, 255);

    // Reset overrides an in-flight reserved push
    set_ready(1'b0);
    drive(1'b1, 25'h1FFFFFF, 3'b111, 5'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(1'b0, '0, 3'b000, '0);
    $display("reset count=%0d illegal_cnt=%0d in_ready=%0d", cnt32, ill32, bus32.in_ready);
    check("rst2.illegal_cnt", ill32, 0);
    check("rst2.count", cnt32, 0);
    check("rst2.in_ready", bus32.in_ready, 1);
    check("rst2.valid", bus32.out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, immediate result width; legal values 32 and 64.
REQ-002 Parameter DEPTH, default 4, output FIFO entries; legal range 2..8, power of two.
REQ-003 Parameter TAG_W, default 5, width of the sideband tag carried alongside each request.
REQ-004 clk  input  1  sole clock; every register samples on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 flush  input  1  synchronous discard of all buffered results.
REQ-007 in_valid  input  1  request present.
REQ-008 in_ready  output  1  request accepted this cycle when high together with in_valid.
REQ-009 in_imm  input  25  instruction bits [31:7].
REQ-010 in_src  input  3  format select.
REQ-011 in_tag  input  TAG_W  opaque tag, returned unchanged with the result.
REQ-012 out_valid  output  1  result at FIFO head.
REQ-013 out_ready  input  1  consumer accepts the head when high together with out_valid.
REQ-014 out_ext  output  XLEN  extended immediate.
REQ-015 out_tag  output  TAG_W  tag of the head entry.
REQ-016 out_illegal  output  1  head entry came from a reserved in_src.
REQ-017 count  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-018 illegal_cnt  output  8  saturating count of accepted reserved-src requests.

Function
REQ-019 The in_src encodings SHALL be: 000 I; 001 S; 101 B; 010 U; 110 J; 011 shamt, zero-extended instr[25:20] (instr[24:20] when XLEN=32); 100 CSR zimm, zero-extended instr[19:15]; 111 reserved.
REQ-020 The I, S, B, U and J formats SHALL follow the RV32I/RV64I immediate layouts, with B and J bit 0 forced to 0, U low 12 bits forced to 0, and sign extension from instr[31] to XLEN.
REQ-021 Reserved src SHALL produce out_ext=0 and out_illegal=1.
REQ-022 A request SHALL be accepted when in_valid and in_ready are both high, and its result SHALL be written into the FIFO on that edge.
REQ-023 Latency SHALL be 1 cycle: a request accepted at edge N into an empty FIFO appears with out_valid=1 after edge N.
REQ-024 in_ready SHALL equal (count != DEPTH) and SHALL NOT depend combinationally on out_ready.
REQ-025 A head pop SHALL occur when out_valid and out_ready are both high; a simultaneous push and pop SHALL leave count unchanged.
REQ-026 The FIFO SHALL be first-in first-out, and the read and write pointers SHALL wrap modulo DEPTH.
REQ-027 While count==0, out_valid, out_ext, out_tag and out_illegal SHALL all be 0.
REQ-028 flush SHALL set count, both pointers and out_valid to 0 on the next edge, and SHALL take priority over a same-cycle push and pop, which are both dropped.
REQ-029 illegal_cnt SHALL increment on each accepted reserved request, including one dropped by flush, and SHALL saturate at 255; flush SHALL NOT clear it.

Reset
REQ-030 While rst_n is low at a clock edge, count, the pointers, out_valid, out_ext, out_tag, out_illegal and illegal_cnt SHALL become 0, and in_ready SHALL be 1 after that edge.
REQ-031 Reset SHALL override flush and any in-flight push or pop, and FIFO contents SHALL be unobservable until rewritten.

Structure
REQ-032 A shared package imm_pkg SHALL hold the src encoding enum and the XLEN default.
REQ-033 The combinational decoder SHALL be a sub-module imm_ext (inputs imm and src; outputs ext and illegal), instantiated once ahead of the FIFO write port.

Verification
REQ-034 XLEN=32, imm=25'b0000000010100000000001000, src 000/001/101/010/110 pushed back-to-back with out_ready=1 -> out_ext 0x0000000A, 0x00000008, 0x00000008, 0x00A00000, 0x0000000A in order, each 1 cycle after acceptance.
REQ-035 XLEN=64, imm=25'h1000000, src=000 -> out_ext=0xFFFFFFFFFFFFF800; src=011, imm=25'h0080000 (instr[26]=1) -> out_ext=0x0000000000000000 under XLEN=32 and 0x0 under XLEN=64 (bit 26 outside shamt).
REQ-036 With out_ready=0, push DEPTH=4 requests with tags 1..4 -> count=4, in_ready=0; a fifth request stalls; then raise out_ready -> tags emerge 1,2,3,4, then 5.
REQ-037 With count=2, assert flush together with in_valid and out_ready -> next cycle count=0 and out_valid=0, and the pushed request is lost.
REQ-038 Push 300 requests with src=111 -> illegal_cnt=255, out_illegal=1 and out_ext=0 on each; then drive rst_n=0 for one edge -> illegal_cnt=0, count=0, in_ready=1.
